// File: rtl/io_timer16x2_pkg.sv
// rtl/io_timer16x2_pkg.sv - shared register-map constants for the dual 16-bit timer
package io_timer16x2_pkg;
    localparam logic [27:0] TIMER_BASE = 28'hFFFFFC2;

    localparam logic [2:0] OFS_MODE0 = 3'h0;
    localparam logic [2:0] OFS_MODE1 = 3'h2;
    localparam logic [2:0] OFS_INIT0 = 3'h4;
    localparam logic [2:0] OFS_INIT1 = 3'h6;

    localparam int MODE_CNT_BIT    = 0;
    localparam int MODE_RELOAD_BIT = 1;
    localparam int STAT_RUN_BIT    = 15;
endpackage

// File: rtl/io_pulse_sync.sv
// rtl/io_pulse_sync.sv - multi-stage synchronizer with rising-edge strobe
module io_pulse_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic strobe
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = pulse_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign strobe = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/io_timer16x2.sv
// rtl/io_timer16x2.sv - two-channel 16-bit timer/counter I/O peripheral
module io_timer16x2 #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic [2:0]       addr,
    input  logic             ior,
    input  logic             iow,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [1:0]       pulse_in,
    output logic [1:0]       cout
);
    import io_timer16x2_pkg::*;

    logic                  rd_en, wr_en;
    logic [2:0]            ofs;
    logic                  unused_addr0;
    logic [1:0][WIDTH-1:0] cnt_all, stat_all;

    assign rd_en        = cs & ior;
    assign wr_en        = cs & iow;
    // byte lane bit is ignored: halfword offsets only
    assign ofs          = {addr[2:1], 1'b0};
    assign unused_addr0 = addr[0];

    for (genvar n = 0; n < 2; n++) begin : g_ch
        localparam logic [2:0] OFS_M = (n == 0) ? OFS_MODE0 : OFS_MODE1;
        localparam logic [2:0] OFS_I = (n == 0) ? OFS_INIT0 : OFS_INIT1;

        logic [1:0]       mode_q, mode_d;
        logic [WIDTH-1:0] init_q, init_d, cnt_q, cnt_d;
        logic             run_q, run_d, cdone_q, cdone_d, tdone_q, tdone_d;
        logic             cout_q, cout_d;
        logic             edge_stb, dec, term, wr_mode, wr_init, rd_stat;

        io_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk      (clk),
            .rst      (rst),
            .pulse_in (pulse_in[n]),
            .strobe   (edge_stb)
        );

        assign wr_mode = wr_en & (ofs == OFS_M);
        assign wr_init = wr_en & (ofs == OFS_I);
        assign rd_stat = rd_en & (ofs == OFS_M);

        always_comb begin
            mode_d  = mode_q;
            init_d  = init_q;
            cnt_d   = cnt_q;
            run_d   = run_q;
            cdone_d = cdone_q;
            tdone_d = tdone_q;
            cout_d  = 1'b0;
            // gating at zero keeps the counter from ever wrapping
            dec  = run_q && (cnt_q != '0) && (mode_q[MODE_CNT_BIT] ? edge_stb : 1'b1);
            term = dec && (cnt_q == WIDTH'(1));

            if (rd_stat) begin
                cdone_d = 1'b0;
                tdone_d = 1'b0;
            end
            if (dec) begin
                cnt_d = cnt_q - WIDTH'(1);
            end
            // terminal set is applied after the read-clear so the event survives
            if (term && !wr_mode && !wr_init) begin
                if (mode_q[MODE_RELOAD_BIT]) begin
                    cnt_d = init_q;
                end else begin
                    cnt_d = '0;
                    run_d = 1'b0;
                end
                if (mode_q[MODE_CNT_BIT]) cdone_d = 1'b1;
                else                      tdone_d = 1'b1;
                cout_d = 1'b1;
            end
            if (wr_mode) begin
                mode_d  = wdata[1:0];
                cnt_d   = cnt_q;
                run_d   = 1'b0;
                cdone_d = 1'b0;
                tdone_d = 1'b0;
            end
            if (wr_init) begin
                init_d = wdata;
                cnt_d  = wdata;
                run_d  = (wdata != '0);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mode_q  <= '0;
                init_q  <= '0;
                cnt_q   <= '0;
                run_q   <= 1'b0;
                cdone_q <= 1'b0;
                tdone_q <= 1'b0;
                cout_q  <= 1'b0;
            end else begin
                mode_q  <= mode_d;
                init_q  <= init_d;
                cnt_q   <= cnt_d;
                run_q   <= run_d;
                cdone_q <= cdone_d;
                tdone_q <= tdone_d;
                cout_q  <= cout_d;
            end
        end

        always_comb begin
            stat_all[n]               = '0;
            stat_all[n][STAT_RUN_BIT] = run_q;
            stat_all[n][1]            = cdone_q;
            stat_all[n][0]            = tdone_q;
        end

        assign cnt_all[n] = cnt_q;
        assign cout[n]    = cout_q;
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            rdata = addr[2] ? cnt_all[addr[1]] : stat_all[addr[1]];
        end
    end
endmodule

// File: tb/tb_io_timer16x2.sv
// tb/tb_io_timer16x2.sv - directed self-checking bench for io_timer16x2
module tb_io_timer16x2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic        ior = 1'b0;
    logic        iow = 1'b0;
    logic [15:0] wdata = 16'd0;
    logic [15:0] rdata;
    logic [1:0]  pulse_in = 2'b00;
    logic [1:0]  cout;

    int n_checks = 0;
    int n_errors = 0;
    int cout1_seen = 0;

    io_timer16x2 #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .addr     (addr),
        .ior      (ior),
        .iow      (iow),
        .wdata    (wdata),
        .rdata    (rdata),
        .pulse_in (pulse_in),
        .cout     (cout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        cs = 1'b1; iow = 1'b1; ior = 1'b0; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; iow = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input string tag, input logic [15:0] exp);
        cs = 1'b1; ior = 1'b1; iow = 1'b0; addr = a;
        #1;
        check_eq(tag, rdata, exp);
        @(negedge clk);
        cs = 1'b0; ior = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: reset state
        bus_read(3'h0, "rst_stat0", 16'h0000);
        bus_read(3'h2, "rst_stat1", 16'h0000);
        bus_read(3'h4, "rst_cnt0", 16'h0000);
        bus_read(3'h6, "rst_cnt1", 16'h0000);
        check_eq("rst_cout", {14'd0, cout}, 16'h0000);

        // 2: timer one-shot from 5
        bus_write(3'h0, 16'h0000);
        bus_write(3'h4, 16'h0005);
        for (int i = 0; i < 6; i++) begin
            cs = 1'b1; ior = 1'b1; addr = 3'h4;
            #1;
            check_eq("t2_cnt0", rdata, 16'(5 - i));
            check_eq("t2_cout0", {15'd0, cout[0]}, (i == 5) ? 16'h0001 : 16'h0000);
            @(negedge clk);
        end
        cs = 1'b0; ior = 1'b0;
        check_eq("t2_cout0_after", {15'd0, cout[0]}, 16'h0000);
        bus_read(3'h0, "t2_stat0", 16'h0001);
        bus_read(3'h0, "t2_stat0_again", 16'h0000);

        // 3: counter reload from 3 with 7 external pulses
        bus_write(3'h2, 16'h0003);
        bus_write(3'h6, 16'h0003);
        for (int p = 1; p <= 7; p++) begin
            pulse_in[1] = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (cout[1]) cout1_seen++;
            end
            pulse_in[1] = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (cout[1]) cout1_seen++;
            end
            if (p == 3) check_eq("t3_cout1_p3", 16'(cout1_seen), 16'd1);
            if (p == 6) check_eq("t3_cout1_p6", 16'(cout1_seen), 16'd2);
        end
        repeat (3) @(negedge clk);
        check_eq("t3_cout1_total", 16'(cout1_seen), 16'd2);
        bus_read(3'h6, "t3_cnt1", 16'h0002);
        bus_read(3'h2, "t3_stat1", 16'h8002);

        // 4: timer reload from 2, status read in the terminal cycle
        bus_write(3'h0, 16'h0002);
        bus_write(3'h4, 16'h0002);
        @(negedge clk);
        bus_read(3'h0, "t4_stat0_term", 16'h8000);
        check_eq("t4_cout0", {15'd0, cout[0]}, 16'h0001);
        bus_read(3'h0, "t4_stat0_next", 16'h8001);

        // 5: INIT write in the terminal cycle wins; INIT 0 never runs
        bus_write(3'h4, 16'h0009);
        check_eq("t5_cout0_none", {15'd0, cout[0]}, 16'h0000);
        bus_read(3'h4, "t5_cnt0_9", 16'h0009);
        bus_read(3'h0, "t5_stat0", 16'h8000);
        bus_write(3'h4, 16'h0000);
        bus_read(3'h0, "t5_stat0_zero", 16'h0000);
        bus_read(3'h4, "t5_cnt0_a", 16'h0000);
        bus_read(3'h4, "t5_cnt0_b", 16'h0000);

        // 6: asynchronous reset mid-count, cout high on channel 1
        bus_write(3'h2, 16'h0000);
        bus_write(3'h4, 16'h0009);
        bus_write(3'h6, 16'h0001);
        @(negedge clk);
        cs = 1'b1; ior = 1'b1; addr = 3'h4;
        #1;
        check_eq("t6_cnt0_pre", rdata, 16'h0007);
        check_eq("t6_cout_pre", {14'd0, cout}, 16'h0002);
        rst = 1'b1;
        #1;
        check_eq("t6_cnt0_rst", rdata, 16'h0000);
        check_eq("t6_cout_rst", {14'd0, cout}, 16'h0000);
        addr = 3'h0;
        #1;
        check_eq("t6_stat0_rst", rdata, 16'h0000);
        @(negedge clk);
        cs = 1'b0; ior = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        cs = 1'b0; iow = 1'b1; addr = 3'h4; wdata = 16'h0005;
        @(negedge clk);
        iow = 1'b0;
        bus_read(3'h4, "t6_nocs_cnt0", 16'h0000);
        bus_read(3'h0, "t6_nocs_stat0", 16'h0000);

        // simultaneous read and write: old value on rdata, write lands
        cs = 1'b1; ior = 1'b1; iow = 1'b1; addr = 3'h6; wdata = 16'h0004;
        #1;
        check_eq("rw_old_cnt1", rdata, 16'h0000);
        @(negedge clk);
        cs = 1'b0; ior = 1'b0; iow = 1'b0;
        bus_read(3'h6, "rw_new_cnt1", 16'h0004);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
